// File: rtl/traffic_pkg.sv
// Shared types and helpers for the multi-approach traffic signal controller.
// Lamp encoding is {red, yellow, green}, one-hot per approach.
package traffic_pkg;

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2,
    WALK    = 2'd3
  } tlc_state_e;

  localparam int DEF_GREEN_T  = 8;
  localparam int DEF_YELLOW_T = 3;
  localparam int DEF_ALLRED_T = 2;
  localparam int DEF_WALK_T   = 5;

  function automatic logic [2:0] lamp_enc(
    input tlc_state_e s,
    input logic       sel
  );
    logic [2:0] v;
    v = 3'b100;
    if (sel && s == GREEN)  v = 3'b001;
    if (sel && s == YELLOW) v = 3'b010;
    return v;
  endfunction

endpackage

// File: rtl/tlc_dwell_timer.sv
// Loadable down-counter holding the dwell of the current controller state.
// Load and decrement both happen only on enabled cycles.
module tlc_dwell_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= RST_VAL;
    end else if (i_en) begin
      if (i_load)
        r_cnt <= i_load_val;
      else if (r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// N-approach traffic controller: dwell timing, demand-driven phase search.
// Define TLC_PED_EN to add the ped_req input, walk lamp and WALK state.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter  int NUM_DIR  = 2,
  parameter  int CNT_W    = 8,
  parameter  int GREEN_T  = DEF_GREEN_T,
  parameter  int YELLOW_T = DEF_YELLOW_T,
  parameter  int ALLRED_T = DEF_ALLRED_T,
  parameter  int WALK_T   = DEF_WALK_T,
  localparam int PW       = $clog2(NUM_DIR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_DIR-1:0] sense,
  output logic [NUM_DIR-1:0] red,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] green,
  output logic [PW-1:0]      phase
`ifdef TLC_PED_EN
  ,
  input  logic               ped_req,
  output logic               walk
`endif
);

  tlc_state_e         r_state;
  tlc_state_e         w_nxt_state;
  logic [PW-1:0]      w_nxt_phase;
  logic [PW-1:0]      w_search;
  logic [CNT_W-1:0]   w_load_val;
  logic [NUM_DIR-1:0] w_red;
  logic [NUM_DIR-1:0] w_yel;
  logic [NUM_DIR-1:0] w_grn;
  logic               w_done;
  logic               w_adv;
  logic               w_ped_pend;

`ifdef TLC_PED_EN
  logic r_ped;
  assign w_ped_pend = r_ped;
`else
  assign w_ped_pend = 1'b0;
`endif

  assign w_adv = en & w_done;

  tlc_dwell_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(ALLRED_T - 1))
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_en       (en),
    .i_load     (w_adv),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  // Scan far-to-near so the nearest demanding approach wins;
  // the current phase itself is the last candidate.
  always_comb begin
    int idx;
    w_search = PW'((int'(phase) + 1) % NUM_DIR);
    for (int i = NUM_DIR; i >= 1; i--) begin
      idx = (int'(phase) + i) % NUM_DIR;
      if (|(sense & (NUM_DIR'(1) << idx)))
        w_search = PW'(idx);
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_phase = phase;
    w_load_val  = '0;
    if (w_adv) begin
      unique case (r_state)
        GREEN: begin
          w_nxt_state = YELLOW;
          w_load_val  = CNT_W'(YELLOW_T - 1);
        end
        YELLOW: begin
          w_nxt_state = ALL_RED;
          w_load_val  = CNT_W'(ALLRED_T - 1);
        end
        ALL_RED: begin
          if (w_ped_pend) begin
            w_nxt_state = WALK;
            w_load_val  = CNT_W'(WALK_T - 1);
          end else begin
            w_nxt_state = GREEN;
            w_nxt_phase = w_search;
            w_load_val  = CNT_W'(GREEN_T - 1);
          end
        end
        WALK: begin
          w_nxt_state = ALL_RED;
          w_load_val  = CNT_W'(ALLRED_T - 1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_red = '0;
    w_yel = '0;
    w_grn = '0;
    for (int i = 0; i < NUM_DIR; i++)
      {w_red[i], w_yel[i], w_grn[i]} =
        lamp_enc(w_nxt_state, w_nxt_phase == PW'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ALL_RED;
      phase   <= PW'(NUM_DIR - 1);
      red     <= '1;
      yellow  <= '0;
      green   <= '0;
`ifdef TLC_PED_EN
      walk    <= 1'b0;
      r_ped   <= 1'b0;
`endif
    end else begin
      r_state <= w_nxt_state;
      phase   <= w_nxt_phase;
      red     <= w_red;
      yellow  <= w_yel;
      green   <= w_grn;
`ifdef TLC_PED_EN
      walk    <= (w_nxt_state == WALK);
      r_ped   <= ped_req |
                 (r_ped & ~(w_nxt_state == WALK &&
                            r_state != WALK));
`endif
    end
  end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Parametrised multi-approach traffic signal controller for the intersection subsystem. It supersedes the fixed three-state red/green/yellow sequencer. It adds N approach phases, programmable dwell times, an all-red clearance interval, demand-driven phase skipping and an optional pedestrian walk phase. All outputs are registered and drive the lamp-driver block directly.

## Interface
- NUM_DIR, 2: number of approach phases; must be ≥2.
- CNT_W, 8: dwell timer width.
- GREEN_T, 8: green dwell in enabled cycles; legal range 1..2**CNT_W-1.
- YELLOW_T, 3: yellow dwell in enabled cycles; same range.
- ALLRED_T, 2: all-red clearance dwell in enabled cycles; same range.
- WALK_T, 5: pedestrian walk dwell in enabled cycles; used only with TLC_PED_EN.
- PW: localparam, $clog2(NUM_DIR).
- clk, in, 1: clock.
- rst, in, 1: reset; asynchronous, active-high.
- en, in, 1: timer advance enable. While low, the state and timer are frozen.
- sense, in, NUM_DIR: per-approach vehicle demand, level-sensitive, sampled only when a phase is selected.
- ped_req, in, 1: pedestrian request pulse. Present only with TLC_PED_EN.
- red, out, NUM_DIR: per-approach red lamp.
- yellow, out, NUM_DIR: per-approach yellow lamp.
- green, out, NUM_DIR: per-approach green lamp.
- phase, out, PW: index of the current or most recent served approach.
- walk, out, 1: pedestrian walk lamp. Present only with TLC_PED_EN.

## Operation
- States: ALL_RED, GREEN, YELLOW, WALK. WALK exists only with TLC_PED_EN.
- Dwell timer:
  - On state entry the timer is loaded with T-1.
  - It decrements on each cycle where en=1.
  - The state transitions on the en=1 cycle where the timer is 0.
  - Each state is therefore held for exactly T enabled cycles.
- Transitions:
  - GREEN → YELLOW.
  - YELLOW → ALL_RED.
  - ALL_RED → WALK if a pedestrian request is pending (TLC_PED_EN); otherwise ALL_RED → GREEN.
  - WALK → ALL_RED.
- Phase selection on ALL_RED → GREEN:
  - The new phase is the first index with sense=1, searching cyclically from (phase+1) mod NUM_DIR and ending with phase itself.
  - If sense is all zero, the new phase is (phase+1) mod NUM_DIR.
- Lamp decode:
  - The approach equal to phase is green in GREEN and yellow in YELLOW.
  - Every other approach, and every approach in ALL_RED or WALK, is red.
  - For every approach, exactly one of red/yellow/green is set in every cycle.
- Wrap-around: phase NUM_DIR-1 followed by 0 is the normal cyclic rotation, not an error.
- Reset state:
  - State is ALL_RED, timer is ALLRED_T-1, phase is NUM_DIR-1. This makes the first search start at 0.
  - red is all ones; yellow and green are all zero; walk is 0; the pending-pedestrian flag is cleared.
- Reset mid-operation: rst forces the reset state immediately, regardless of state or timer value. No yellow is inserted.

## Timing
- Outputs are registered and change on the same edge as the state register. Latency from state change to lamp output is zero additional cycles.
- Sequence after rst deassertion with en=1 and no demand or pedestrians:
  - ALL_RED for ALLRED_T cycles.
  - Then, per approach, GREEN GREEN_T → YELLOW YELLOW_T → ALL_RED ALLRED_T.
  - Each approach period is GREEN_T+YELLOW_T+ALLRED_T cycles.
- sense is sampled on the single ALL_RED exit edge. Changes at any other time have no effect.
- en low for k cycles extends the current dwell by exactly k cycles. Lamps are unchanged during the freeze.

## Configuration
- TLC_PED_EN defined:
  - ped_req and walk ports exist.
  - A ped_req pulse (any cycle, any state) sets a sticky pending flag. Repeated requests merge into the one pending flag.
  - At the ALL_RED exit, if the flag is set, the controller enters WALK for WALK_T cycles with walk=1 and all approaches red. The flag clears on WALK entry.
  - WALK is followed by ALL_RED for ALLRED_T cycles, then normal phase selection. phase is unchanged across WALK.
  - A ped_req arriving during WALK re-arms the flag for the next ALL_RED exit.
- TLC_PED_EN undefined: ped_req and walk ports and the WALK state are absent. Behaviour is otherwise identical.

## Structure
- Package traffic_pkg: state enum tlc_state_e (ALL_RED, GREEN, YELLOW, WALK), default dwell constants, lamp-encoding helper.
- Sub-module tlc_dwell_timer: loadable CNT_W down-counter with en and a done flag, instantiated once.
- The top level holds the state register, phase register, cyclic priority search, pedestrian flag and lamp decode.

## Test plan
All scenarios use defaults unless stated.
- Reset sequence: rst deasserted, sense=0 → red=2'b11 for 2 cycles; then green=2'b01 for 8 cycles; yellow=2'b01 for 3; red=2'b11 for 2; then green=2'b10.
- Demand skip: NUM_DIR=4, sense=4'b1000 held → green serves only approach 3 on every rotation, with phase=3.
- en freeze: en low for 4 cycles during GREEN → green lasts 12 clock cycles and the lamps do not change while en is low.
- Mid-operation reset: rst asserted during YELLOW → same cycle red=all ones and yellow=0; phase reads NUM_DIR-1; the full reset sequence then repeats.
- Pedestrian (TLC_PED_EN): ped_req pulse during GREEN of phase 0 → after YELLOW and ALL_RED, walk=1 for 5 cycles with red=2'b11; then ALL_RED for 2 cycles; then green=2'b10.
- Lamp exclusivity: random sense, en and ped_req for 10k cycles → assertion that each approach has exactly one lamp set and at most one approach is non-red.
